flags_condition_unit: RTL and testbench
=======================================

// Module: flags_condition_unit
// PURPOSE
//  Status-flag register plus condition evaluator feeding the CPU's conditional-execute path.
//  Latches each instruction's condition code and set-flags request, then drives _do_exec from
//  the committed czonENGL flags and the UART ready lines.
//  Commits ALU flags only when the instruction both requests it and actually executes.
//  Sits between the ALU flag outputs and the control decoder; replaces the gated_flags_clk scheme.
// PARAMETERS
//  CNT_W  16  width of the saturating executed/skipped instruction counters
// PORTS
//  clk                input   1      system clock; all state changes on rising edge
//  reset              input   1      synchronous, active-high reset
//  instr_valid        input   1      1-cycle pulse: condition/_set_flags valid for a new instruction
//  condition          input   4      condition code of the instruction being issued
//  _set_flags         input   1      active-low: instruction requests a flag update
//  exec_done          input   1      1-cycle pulse: end of execute phase, ALU flags settled
//  alu_flags_czonENGL input   8      ALU flags {c,z,o,n,E,N,G,L}, bit7 = c
//  _flag_di           input   1      active-low UART data-in-ready
//  _flag_do           input   1      active-low UART data-out-ready
//  flags_czonENGL     output  8      committed status register
//  _do_exec           output  1      active-low: current instruction executes
//  in_exec            output  1      1 while state = EXEC
//  proto_err          output  1      sticky protocol-violation flag
//  exec_count         output  CNT_W  instructions executed (saturating)
//  skip_count         output  CNT_W  instructions suppressed (saturating)
// BEHAVIOUR
//  Reset (sync, wins over every other input): state=FETCH, flags=8'h00, cond_q=0, setf_q=1,
//   _do_exec=1, in_exec=0, proto_err=0, both counters=0.
//  FETCH: instr_valid -> cond_q<=condition, setf_q<=_set_flags, state<=EXEC (next cycle).
//   exec_done in FETCH: ignored, proto_err<=1.
//  EXEC: _do_exec = !cond_true(cond_q), evaluated combinationally from flags_czonENGL
//   (pre-commit value) and live _flag_di/_flag_do. _do_exec is forced 1 outside EXEC.
//   exec_done -> if (!setf_q && !_do_exec) flags<=alu_flags_czonENGL; else flags held.
//     Same edge: exec_count+1 if executed, else skip_count+1; state<=FETCH.
//   instr_valid in EXEC (not coincident with exec_done): ignored, proto_err<=1.
//   instr_valid && exec_done together in EXEC: commit, then go straight to EXEC with the new
//     condition (back-to-back issue); no error.
//  Condition codes (true when): 0 A always; 1 C c; 2 Z z; 3 O o; 4 N n; 5 EQ E; 6 NE N;
//   7 GT G; 8 LT L; 9 DI !_flag_di; 10 DO !_flag_do; 11 NC !c; 12 NZ !z; 13 NO !o;
//   14 NN !n; 15 NEVER.
//  Instruction skipped => flags never written regardless of _set_flags.
//  Instruction executed without set-flags => flags persist unchanged across any number of cycles.
//  Flags committed at exec_done are visible to the next instruction's condition.
//  Counters saturate at all-ones and never wrap; proto_err is cleared only by reset.
//  Reset mid-EXEC: any pending commit is discarded; flags return to 0.
// TESTING
//  1 reset held 2 cycles -> flags=00, _do_exec=1, in_exec=0, counters=0, proto_err=0.
//  2 cond=A, _set_flags=0, alu=8'b00111010, exec_done -> flags=00111010, exec_count=1.
//  3 then cond=A, _set_flags=1, alu=8'b11111010 -> flags stay 00111010; next A with
//    _set_flags=0, alu=8'b11111010 -> flags=11111010.
//  4 flags c=0, cond=C, _set_flags=0, alu=8'hFF -> _do_exec=1 during EXEC, flags unchanged,
//    skip_count+1.
//  5 cond=DI with _flag_di=0 -> _do_exec=0; _flag_di=1 -> 1. exec_done in FETCH -> proto_err=1.
//  6 reset asserted on exec_done edge -> flags=00, state FETCH; force exec_count=all-ones,
//    execute once more -> stays all-ones.

Source files
------------

// File: rtl/flags_condition_unit.sv
// Status-flag register and condition evaluator for conditional execute.
// Latches condition/set-flags per instruction and commits ALU flags.
module flags_condition_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [3:0]       condition,
  input  logic             _set_flags,
  input  logic             exec_done,
  input  logic [7:0]       alu_flags_czonENGL,
  input  logic             _flag_di,
  input  logic             _flag_do,
  output logic [7:0]       flags_czonENGL,
  output logic             _do_exec,
  output logic             in_exec,
  output logic             proto_err,
  output logic [CNT_W-1:0] exec_count,
  output logic [CNT_W-1:0] skip_count
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_e;

  localparam logic [3:0] C_A     = 4'd0;
  localparam logic [3:0] C_C     = 4'd1;
  localparam logic [3:0] C_Z     = 4'd2;
  localparam logic [3:0] C_O     = 4'd3;
  localparam logic [3:0] C_N     = 4'd4;
  localparam logic [3:0] C_EQ    = 4'd5;
  localparam logic [3:0] C_NE    = 4'd6;
  localparam logic [3:0] C_GT    = 4'd7;
  localparam logic [3:0] C_LT    = 4'd8;
  localparam logic [3:0] C_DI    = 4'd9;
  localparam logic [3:0] C_DO    = 4'd10;
  localparam logic [3:0] C_NC    = 4'd11;
  localparam logic [3:0] C_NZ    = 4'd12;
  localparam logic [3:0] C_NO    = 4'd13;
  localparam logic [3:0] C_NN    = 4'd14;
  localparam logic [3:0] C_NEVER = 4'd15;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [7:0]       flags_q, flags_d;
  logic [3:0]       cond_q, cond_d;
  logic             setf_q, setf_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;

  logic f_c, f_z, f_o, f_n;
  logic f_e, f_ne, f_g, f_l;
  logic cond_true;
  logic do_exec_n;
  logic retire;
  logic load;

  assign f_c  = flags_q[7];
  assign f_z  = flags_q[6];
  assign f_o  = flags_q[5];
  assign f_n  = flags_q[4];
  assign f_e  = flags_q[3];
  assign f_ne = flags_q[2];
  assign f_g  = flags_q[1];
  assign f_l  = flags_q[0];

  // Decode the latched condition against committed flags and live UART lines
  always_comb begin
    cond_true = 1'b0;
    case (cond_q)
      C_A:     cond_true = 1'b1;
      C_C:     cond_true = f_c;
      C_Z:     cond_true = f_z;
      C_O:     cond_true = f_o;
      C_N:     cond_true = f_n;
      C_EQ:    cond_true = f_e;
      C_NE:    cond_true = f_ne;
      C_GT:    cond_true = f_g;
      C_LT:    cond_true = f_l;
      C_DI:    cond_true = !_flag_di;
      C_DO:    cond_true = !_flag_do;
      C_NC:    cond_true = !f_c;
      C_NZ:    cond_true = !f_z;
      C_NO:    cond_true = !f_o;
      C_NN:    cond_true = !f_n;
      C_NEVER: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

  assign do_exec_n = (state_q == EXEC) ? !cond_true : 1'b1;
  assign retire    = (state_q == EXEC) && exec_done;
  assign load      = instr_valid && ((state_q == FETCH) || exec_done);

  // Next-state, flag commit, counters and protocol checking
  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    cond_d  = cond_q;
    setf_d  = setf_q;
    err_d   = err_q;
    ecnt_d  = ecnt_q;
    scnt_d  = scnt_q;

    if (load) begin
      cond_d = condition;
      setf_d = _set_flags;
    end

    case (state_q)
      FETCH: begin
        if (exec_done) begin
          err_d = 1'b1;
        end
        if (instr_valid) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (exec_done) begin
          if (!setf_q && !do_exec_n) begin
            flags_d = alu_flags_czonENGL;
          end
          if (!do_exec_n) begin
            if (ecnt_q != CNT_MAX) begin
              ecnt_d = ecnt_q + 1'b1;
            end
          end else begin
            if (scnt_q != CNT_MAX) begin
              scnt_d = scnt_q + 1'b1;
            end
          end
          state_d = instr_valid ? EXEC : FETCH;
        end else if (instr_valid) begin
          err_d = 1'b1;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // State registers with synchronous reset that overrides everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      flags_q <= 8'h00;
      cond_q  <= 4'h0;
      setf_q  <= 1'b1;
      err_q   <= 1'b0;
      ecnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      cond_q  <= cond_d;
      setf_q  <= setf_d;
      err_q   <= err_d;
      ecnt_q  <= ecnt_d;
      scnt_q  <= scnt_d;
    end
  end

  assign flags_czonENGL = flags_q;
  assign _do_exec       = do_exec_n;
  assign in_exec        = (state_q == EXEC);
  assign proto_err      = err_q;
  assign exec_count     = ecnt_q;
  assign skip_count     = scnt_q;

  logic unused_retire;
  assign unused_retire = retire;

endmodule

// File: tb/tb_flags_condition_unit.sv
// Bench for flags_condition_unit: vector table plus scoreboard,
// with hand sequences for reset, protocol and saturation corners.
module tb_flags_condition_unit;

  localparam int CW = 4;
  localparam logic [CW-1:0] MAXC = {CW{1'b1}};

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic [3:0]    condition;
  logic          _set_flags;
  logic          exec_done;
  logic [7:0]    alu_flags_czonENGL;
  logic          _flag_di;
  logic          _flag_do;
  logic [7:0]    flags_czonENGL;
  logic          _do_exec;
  logic          in_exec;
  logic          proto_err;
  logic [CW-1:0] exec_count;
  logic [CW-1:0] skip_count;

  flags_condition_unit #(.CNT_W(CW)) dut (
    .clk                (clk),
    .reset              (reset),
    .instr_valid        (instr_valid),
    .condition          (condition),
    ._set_flags         (_set_flags),
    .exec_done          (exec_done),
    .alu_flags_czonENGL (alu_flags_czonENGL),
    ._flag_di           (_flag_di),
    ._flag_do           (_flag_do),
    .flags_czonENGL     (flags_czonENGL),
    ._do_exec           (_do_exec),
    .in_exec            (in_exec),
    .proto_err          (proto_err),
    .exec_count         (exec_count),
    .skip_count         (skip_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cond;
    logic       setf_n;
    logic [7:0] alu;
    logic       di_n;
    logic       do_n;
    logic       exp_do_exec_n;
  } vec_t;

  typedef struct {
    logic [7:0]    flags;
    logic [CW-1:0] ecnt;
    logic [CW-1:0] scnt;
  } exp_t;

  vec_t vecs[22];
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  logic [7:0]    m_flags;
  logic [CW-1:0] m_ecnt;
  logic [CW-1:0] m_scnt;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_flags = 8'h00;
    m_ecnt  = '0;
    m_scnt  = '0;
  endtask

  function automatic logic m_true(input logic [3:0] c, input logic [7:0] f,
                                  input logic di_n, input logic do_n);
    logic [15:0] t;
    t = {1'b0, !f[4], !f[5], !f[6], !f[7], !do_n, !di_n,
         f[0], f[1], f[2], f[3], f[4], f[5], f[6], f[7], 1'b1};
    return t[c];
  endfunction

  task automatic do_reset(input int n);
    reset = 1'b1;
    instr_valid = 1'b0;
    exec_done = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic issue(input logic [3:0] c, input logic s);
    instr_valid = 1'b1;
    condition   = c;
    _set_flags  = s;
    tick();
    instr_valid = 1'b0;
  endtask

  // One full instruction: issue, check EXEC outputs, retire, score
  task automatic run_instr(input string tag, input logic [3:0] c,
                           input logic s, input logic [7:0] alu,
                           input logic exp_n, input logic use_exp);
    logic ex;
    exp_t e;
    exp_t g;
    issue(c, s);
    ex = m_true(c, m_flags, _flag_di, _flag_do);
    if (use_exp) chk({tag, "_tbl"}, 32'(!ex), 32'(exp_n));
    chk({tag, "_inexec"}, 32'(in_exec), 32'd1);
    chk({tag, "_doexec"}, 32'(_do_exec), 32'(!ex));
    if (ex && !s) m_flags = alu;
    if (ex) begin
      if (m_ecnt != MAXC) m_ecnt++;
    end else begin
      if (m_scnt != MAXC) m_scnt++;
    end
    e.flags = m_flags;
    e.ecnt  = m_ecnt;
    e.scnt  = m_scnt;
    sb.push_back(e);
    exec_done = 1'b1;
    alu_flags_czonENGL = alu;
    tick();
    exec_done = 1'b0;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      g = sb.pop_front();
      chk({tag, "_flags"}, 32'(flags_czonENGL), 32'(g.flags));
      chk({tag, "_ecnt"}, 32'(exec_count), 32'(g.ecnt));
      chk({tag, "_scnt"}, 32'(skip_count), 32'(g.scnt));
      chk({tag, "_fetch"}, 32'(in_exec), 32'd0);
    end
  endtask

  initial begin
    vecs[0]  = '{4'd0,  1'b0, 8'h3A, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{4'd0,  1'b1, 8'hFA, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{4'd0,  1'b0, 8'hFA, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{4'd1,  1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{4'd1,  1'b0, 8'hFF, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{4'd11, 1'b0, 8'h05, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{4'd6,  1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{4'd5,  1'b0, 8'hFF, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{4'd8,  1'b0, 8'h48, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{4'd2,  1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{4'd12, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{4'd9,  1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{4'd9,  1'b1, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{4'd10, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{4'd10, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[15] = '{4'd15, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{4'd7,  1'b0, 8'h20, 1'b1, 1'b1, 1'b1};
    vecs[17] = '{4'd5,  1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
    vecs[18] = '{4'd3,  1'b1, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[19] = '{4'd13, 1'b0, 8'h10, 1'b1, 1'b1, 1'b0};
    vecs[20] = '{4'd4,  1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[21] = '{4'd14, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};

    reset = 1'b1;
    instr_valid = 1'b0;
    condition = 4'd0;
    _set_flags = 1'b1;
    exec_done = 1'b0;
    alu_flags_czonENGL = 8'h00;
    _flag_di = 1'b1;
    _flag_do = 1'b1;
    model_reset();
    #1;

    do_reset(2);
    chk("rst_flags", 32'(flags_czonENGL), 32'h00);
    chk("rst_doexec", 32'(_do_exec), 32'd1);
    chk("rst_inexec", 32'(in_exec), 32'd0);
    chk("rst_ecnt", 32'(exec_count), 32'd0);
    chk("rst_scnt", 32'(skip_count), 32'd0);
    chk("rst_err", 32'(proto_err), 32'd0);

    for (int i = 0; i < 22; i++) begin
      _flag_di = vecs[i].di_n;
      _flag_do = vecs[i].do_n;
      run_instr($sformatf("v%0d", i), vecs[i].cond, vecs[i].setf_n,
                vecs[i].alu, vecs[i].exp_do_exec_n, 1'b1);
    end
    _flag_di = 1'b1;
    _flag_do = 1'b1;
    chk("tbl_err", 32'(proto_err), 32'd0);

    do_reset(1);
    run_instr("t2", 4'd0, 1'b0, 8'b00111010, 1'b0, 1'b1);
    chk("t2_flags", 32'(flags_czonENGL), 32'b00111010);
    chk("t2_ecnt", 32'(exec_count), 32'd1);

    // DI follows the live UART line while in EXEC
    issue(4'd9, 1'b1);
    _flag_di = 1'b0;
    #1;
    chk("di_low", 32'(_do_exec), 32'd0);
    _flag_di = 1'b1;
    #1;
    chk("di_high", 32'(_do_exec), 32'd1);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("di_skip", 32'(skip_count), 32'd1);

    // Back-to-back: retire and issue on the same edge
    alu_flags_czonENGL = 8'h01;
    issue(4'd0, 1'b0);
    instr_valid = 1'b1;
    condition = 4'd8;
    _set_flags = 1'b0;
    exec_done = 1'b1;
    tick();
    instr_valid = 1'b0;
    exec_done = 1'b0;
    chk("b2b_flags", 32'(flags_czonENGL), 32'h01);
    chk("b2b_inexec", 32'(in_exec), 32'd1);
    chk("b2b_doexec", 32'(_do_exec), 32'd0);
    chk("b2b_err", 32'(proto_err), 32'd0);
    alu_flags_czonENGL = 8'h00;
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("b2b_flags2", 32'(flags_czonENGL), 32'h00);
    chk("b2b_ecnt", 32'(exec_count), 32'd3);

    // exec_done with nothing in flight is a protocol error
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("err_fetch", 32'(proto_err), 32'd1);
    tick();
    chk("err_sticky", 32'(proto_err), 32'd1);
    do_reset(1);
    chk("err_clear", 32'(proto_err), 32'd0);
    issue(4'd0, 1'b1);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("err_exec", 32'(proto_err), 32'd1);
    chk("err_exec_st", 32'(in_exec), 32'd1);

    // Reset on the retire edge discards the pending commit
    do_reset(1);
    run_instr("pre", 4'd0, 1'b0, 8'hAA, 1'b0, 1'b0);
    issue(4'd0, 1'b0);
    alu_flags_czonENGL = 8'hFF;
    exec_done = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exec_done = 1'b0;
    model_reset();
    chk("mid_flags", 32'(flags_czonENGL), 32'h00);
    chk("mid_inexec", 32'(in_exec), 32'd0);
    chk("mid_ecnt", 32'(exec_count), 32'd0);

    // Saturation of the executed counter
    for (int i = 0; i < 17; i++) begin
      run_instr($sformatf("sat%0d", i), 4'd0, 1'b1, 8'h00, 1'b0, 1'b0);
    end
    chk("sat_ecnt", 32'(exec_count), 32'(MAXC));
    chk("sat_scnt", 32'(skip_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
